// File: rtl/wb_regfile_pkg.sv
// Pipeline package shared by the control decoder and the writeback stage.
// Holds the architectural register numbers that carry special meaning and
// the writeback-source encoding, plus the helper that turns the WR-stage
// control bits into a source selection.
package wb_regfile_pkg;

  // x0 always reads as zero; x31 is the link register written by jal/jalr.
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 31;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_src_e;

  // Link has priority over MemtoReg: a jump never loads, so a stray
  // MemtoReg alongside Link must not steal the link value.
  function automatic wb_src_e wb_src_sel(input logic link, input logic mem_to_reg);
    if (link)            return WB_LINK;
    else if (mem_to_reg) return WB_MEM;
    else                 return WB_ALU;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Plain 2-read / 1-write register array.
// No bypass and no zero-register rule; the wrapper adds those.
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high clear
//   we, waddr, wdata   write port, committed at posedge clk
//   raddr_a, rdata_a   combinational read port A
//   raddr_b, rdata_b   combinational read port B
module regfile_2r1w #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] regs [DEPTH];

  // NOTE: the array is cleared on reset because software relies on every
  // register reading zero after reset; this rules out mapping it to a RAM
  // macro, which is acceptable at 32 entries.
  // NOTE: sequential state is always updated with <= so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and general-purpose register file.
// Selects the writeback value from the registered WR-stage bundle, commits
// it into the register file, serves the two ID-stage read ports with
// write-through bypass, and keeps a small commit trace.
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   WR_pc, WR_pc_plus4            PC and link value of the instruction in WR
//   WR_dout, WR_ALUresult         load data and ALU result
//   WR_Rw, WR_RegWrite            destination register and write enable
//   WR_MemtoReg, WR_Link          writeback source select (Link has priority)
//   Ra/busA, Rb/busB              combinational read ports with bypass
//   wb_data, wb_we                selected value and effective write enable
//   wb_cnt, last_wb_pc,
//   last_wb_valid                 commit trace
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    WR_pc,
  input  logic [DW-1:0]    WR_pc_plus4,
  input  logic [DW-1:0]    WR_dout,
  input  logic [DW-1:0]    WR_ALUresult,
  input  logic [AW-1:0]    WR_Rw,
  input  logic             WR_RegWrite,
  input  logic             WR_MemtoReg,
  input  logic             WR_Link,
  input  logic [AW-1:0]    Ra,
  input  logic [AW-1:0]    Rb,
  output logic [DW-1:0]    busA,
  output logic [DW-1:0]    busB,
  output logic [DW-1:0]    wb_data,
  output logic             wb_we,
  output logic [CNT_W-1:0] wb_cnt,
  output logic [DW-1:0]    last_wb_pc,
  output logic             last_wb_valid
);

  wb_src_e       wb_src;
  logic [DW-1:0] raw_a;
  logic [DW-1:0] raw_b;

  assign wb_src = wb_src_sel(WR_Link, WR_MemtoReg);

  // NOTE: every output of an always_comb gets a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wb_data = WR_ALUresult;
    case (wb_src)
      WB_LINK: wb_data = WR_pc_plus4;
      WB_MEM:  wb_data = WR_dout;
      default: wb_data = WR_ALUresult;
    endcase
  end

  // Writes to x0 are dropped here, so neither the array nor the trace
  // ever sees them. Reset masks the enable so the instruction in WR is lost.
  assign wb_we = WR_RegWrite & (WR_Rw != AW'(REG_ZERO)) & ~rst;

  regfile_2r1w #(
    .DW (DW),
    .AW (AW)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (WR_Rw),
    .wdata   (wb_data),
    .raddr_a (Ra),
    .raddr_b (Rb),
    .rdata_a (raw_a),
    .rdata_b (raw_b)
  );

  // Bypass makes a write in WR visible to ID in the same cycle, so the
  // pipeline sees write-before-read without an extra stall.
  function automatic logic [DW-1:0] read_mux(input logic [AW-1:0] addr,
                                             input logic [DW-1:0] raw);
    if (rst || addr == AW'(REG_ZERO)) return '0;
    else if (wb_we && WR_Rw == addr)  return wb_data;
    else                              return raw;
  endfunction

  assign busA = read_mux(Ra, raw_a);
  assign busB = read_mux(Rb, raw_b);

  // Commit trace; the counter wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cnt        <= '0;
      last_wb_pc    <= '0;
      last_wb_valid <= 1'b0;
    end else if (wb_we) begin
      wb_cnt        <= wb_cnt + 1'b1;
      last_wb_pc    <= WR_pc;
      last_wb_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile. A second instance with a 4-bit
// commit counter shares the stimulus so counter wrap is reachable quickly.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] WR_pc, WR_pc_plus4, WR_dout, WR_ALUresult;
  logic [4:0]  WR_Rw, Ra, Rb;
  logic        WR_RegWrite, WR_MemtoReg, WR_Link;

  logic [31:0] busA, busB, wb_data, wb_cnt, last_wb_pc;
  logic        wb_we, last_wb_valid;

  logic [31:0] busA4, busB4, wb_data4, last_wb_pc4;
  logic [3:0]  wb_cnt4;
  logic        wb_we4, last_wb_valid4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk (clk), .rst (rst),
    .WR_pc (WR_pc), .WR_pc_plus4 (WR_pc_plus4), .WR_dout (WR_dout),
    .WR_ALUresult (WR_ALUresult), .WR_Rw (WR_Rw), .WR_RegWrite (WR_RegWrite),
    .WR_MemtoReg (WR_MemtoReg), .WR_Link (WR_Link),
    .Ra (Ra), .Rb (Rb), .busA (busA), .busB (busB),
    .wb_data (wb_data), .wb_we (wb_we), .wb_cnt (wb_cnt),
    .last_wb_pc (last_wb_pc), .last_wb_valid (last_wb_valid)
  );

  wb_regfile #(.CNT_W(4)) dut4 (
    .clk (clk), .rst (rst),
    .WR_pc (WR_pc), .WR_pc_plus4 (WR_pc_plus4), .WR_dout (WR_dout),
    .WR_ALUresult (WR_ALUresult), .WR_Rw (WR_Rw), .WR_RegWrite (WR_RegWrite),
    .WR_MemtoReg (WR_MemtoReg), .WR_Link (WR_Link),
    .Ra (Ra), .Rb (Rb), .busA (busA4), .busB (busB4),
    .wb_data (wb_data4), .wb_we (wb_we4), .wb_cnt (wb_cnt4),
    .last_wb_pc (last_wb_pc4), .last_wb_valid (last_wb_valid4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [4:0] rw, input logic [31:0] alu,
                             input logic mem, input logic link,
                             input logic [31:0] dout, input logic [31:0] pc4,
                             input logic [31:0] pc);
    WR_RegWrite  = 1'b1;
    WR_Rw        = rw;
    WR_ALUresult = alu;
    WR_MemtoReg  = mem;
    WR_Link      = link;
    WR_dout      = dout;
    WR_pc_plus4  = pc4;
    WR_pc        = pc;
  endtask

  task automatic bubble();
    WR_RegWrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    WR_pc = '0; WR_pc_plus4 = '0; WR_dout = '0; WR_ALUresult = '0;
    WR_Rw = '0; WR_RegWrite = 1'b0; WR_MemtoReg = 1'b0; WR_Link = 1'b0;
    Ra = '0; Rb = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("init_cnt",   wb_cnt, 32'd0);
    check("init_valid", {31'd0, last_wb_valid}, 32'd0);

    // Preload x5, then reset and confirm it is cleared.
    drive_write(5'd5, 32'hDEAD, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10);
    step(); bubble(); Ra = 5'd5; #1;
    check("preload_x5", busA, 32'hDEAD);
    rst = 1'b1; #1;
    check("busA_in_rst", busA, 32'd0);
    step(); rst = 1'b0; #1;
    check("rst_x5",    busA, 32'd0);
    check("rst_cnt",   wb_cnt, 32'd0);
    check("rst_valid", {31'd0, last_wb_valid}, 32'd0);
    check("rst_pc",    last_wb_pc, 32'd0);

    // ALU write, visible next cycle.
    drive_write(5'd8, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40);
    step(); bubble(); Ra = 5'd8; #1;
    check("alu_x8",     busA, 32'h1234);
    check("alu_cnt",    wb_cnt, 32'd1);
    check("alu_pc",     last_wb_pc, 32'h40);
    check("alu_valid",  {31'd0, last_wb_valid}, 32'd1);

    // Same-cycle bypass on both ports from a load.
    drive_write(5'd9, 32'h1111, 1'b1, 1'b0, 32'hCAFE, 32'h0, 32'h44);
    Ra = 5'd9; Rb = 5'd9; #1;
    check("byp_busA",   busA, 32'hCAFE);
    check("byp_busB",   busB, 32'hCAFE);
    check("byp_wbdata", wb_data, 32'hCAFE);
    check("byp_we",     {31'd0, wb_we}, 32'd1);
    step(); bubble(); #1;
    check("mem_x9",  busB, 32'hCAFE);
    check("mem_cnt", wb_cnt, 32'd2);

    // Link beats MemtoReg.
    drive_write(5'd31, 32'h7777, 1'b1, 1'b1, 32'h5555, 32'h104, 32'h100);
    #1;
    check("link_wbdata", wb_data, 32'h104);
    step(); bubble(); Ra = 5'd31; #1;
    check("link_x31", busA, 32'h104);
    check("link_pc",  last_wb_pc, 32'h100);
    check("link_cnt", wb_cnt, 32'd3);

    // Write to x0 is dropped.
    drive_write(5'd0, 32'hFFFF, 1'b0, 1'b0, 32'h0, 32'h0, 32'h200);
    Ra = 5'd0; #1;
    check("x0_busA_now", busA, 32'd0);
    check("x0_we",       {31'd0, wb_we}, 32'd0);
    step(); bubble(); #1;
    check("x0_busA",  busA, 32'd0);
    check("x0_cnt",   wb_cnt, 32'd3);
    check("x0_pc",    last_wb_pc, 32'h100);

    // Bubble aimed at x3 leaves it unchanged and is not bypassed.
    drive_write(5'd3, 32'h3333, 1'b0, 1'b0, 32'h0, 32'h0, 32'h300);
    step();
    bubble(); WR_Rw = 5'd3; WR_ALUresult = 32'hABCD; WR_pc = 32'h304; Ra = 5'd3; #1;
    check("bub_busA_now", busA, 32'h3333);
    step(); #1;
    check("bub_x3",  busA, 32'h3333);
    check("bub_cnt", wb_cnt, 32'd4);
    check("bub_pc",  last_wb_pc, 32'h300);

    // Back-to-back writes to x10: read between them sees the second via bypass.
    drive_write(5'd10, 32'hA1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h400);
    step();
    drive_write(5'd10, 32'hA2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h404);
    Ra = 5'd10; #1;
    check("b2b_bypass", busA, 32'hA2);
    step(); bubble(); #1;
    check("b2b_x10", busA, 32'hA2);
    check("b2b_pc",  last_wb_pc, 32'h404);
    check("b2b_cnt", wb_cnt, 32'd6);

    // Reset dominates a concurrent write, mid-stream.
    drive_write(5'd4, 32'h4444, 1'b0, 1'b0, 32'h0, 32'h0, 32'h500);
    rst = 1'b1; Ra = 5'd4; #1;
    check("rstw_we", {31'd0, wb_we}, 32'd0);
    step(); rst = 1'b0; bubble(); #1;
    check("rstw_x4",    busA, 32'd0);
    check("rstw_cnt",   wb_cnt, 32'd0);
    check("rstw_valid", {31'd0, last_wb_valid}, 32'd0);
    Ra = 5'd8; #1;
    check("rstw_x8", busA, 32'd0);

    // 16 commits: the 4-bit counter wraps, the 32-bit one does not.
    for (int i = 1; i <= 16; i++) begin
      drive_write(5'(i), 32'(i * 3), 1'b0, 1'b0, 32'h0, 32'h0, 32'h600 + 32'(i * 4));
      step();
      if (i == 15) check("wrap_cnt4_15", {28'd0, wb_cnt4}, 32'd15);
    end
    bubble(); Ra = 5'd16; #1;
    check("wrap_cnt4",   {28'd0, wb_cnt4}, 32'd0);
    check("wrap_valid4", {31'd0, last_wb_valid4}, 32'd1);
    check("wrap_cnt32",  wb_cnt, 32'd16);
    check("wrap_pc",     last_wb_pc, 32'h640);
    check("wrap_x16",    busA, 32'd48);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WR pipeline register.
- Takes the registered WR-stage bundle, selects the writeback value, and commits it into a 32x32 general-purpose register file.
- Serves the two ID-stage read ports, with write-through bypass.
- Keeps a writeback trace: count of committed writes, plus PC and valid flag of the last commit.

Parameters:
- DW, 32, data/PC width.
- AW, 5, register address width; the file holds 2**AW entries.
- CNT_W, 32, width of the writeback commit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- WR_pc  input  DW  PC of the instruction in WR.
- WR_pc_plus4  input  DW  link value for jal/jalr.
- WR_dout  input  DW  load data from memory.
- WR_ALUresult  input  DW  ALU result.
- WR_Rw  input  AW  destination register.
- WR_RegWrite  input  1  write enable.
- WR_MemtoReg  input  1  1 selects WR_dout.
- WR_Link  input  1  1 selects WR_pc_plus4; overrides MemtoReg.
- Ra  input  AW  read address A.
- Rb  input  AW  read address B.
- busA  output  DW  read data A.
- busB  output  DW  read data B.
- wb_data  output  DW  selected writeback value (combinational), used for EX forwarding.
- wb_we  output  1  effective write enable = WR_RegWrite & (WR_Rw!=0) & !rst.
- wb_cnt  output  CNT_W  number of committed writes.
- last_wb_pc  output  DW  WR_pc of the most recent committed write.
- last_wb_valid  output  1  set once any write has committed since reset.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, on ports clk and rst.
- Writeback select (combinational, priority order):
  - WR_Link=1 -> WR_pc_plus4;
  - else WR_MemtoReg=1 -> WR_dout;
  - else WR_ALUresult.
- Commit: at posedge clk, when wb_we=1, regs[WR_Rw] <= wb_data. Latency is one edge; the value is visible in the array from the next cycle.
- Register 0 is hardwired to 0:
  - writes to it are dropped;
  - they do not increment wb_cnt and do not update last_wb_pc.
- Reads are combinational:
  - busA = 0 if Ra==0;
  - else wb_data if wb_we & (WR_Rw==Ra), same-cycle bypass giving write-before-read semantics;
  - else regs[Ra].
  - busB follows the same rules with Rb.
  - Both ports may hit the same address and the bypass simultaneously.
- While rst=1: busA=busB=0, bypass disabled, wb_we=0.
- Reset (synchronous, at posedge with rst=1):
  - all regs <= 0; wb_cnt <= 0; last_wb_pc <= 0; last_wb_valid <= 0.
  - rst dominates any concurrent write; the instruction in WR is lost.
  - Reset asserted mid-stream behaves identically.
- Trace, on each commit:
  - wb_cnt <= wb_cnt+1, wrapping modulo 2**CNT_W with no saturation;
  - last_wb_pc <= WR_pc;
  - last_wb_valid <= 1, sticky until reset.
- Bubbles (WR_RegWrite=0) leave all state unchanged.
- The block holds no other state.
- X on inputs while WR_RegWrite=0 must not corrupt state.
- Back-to-back writes to the same register: the later edge wins. A read in the cycle between the two writes returns the bypassed value of the second write if it is in WR then.

Decomposition:
- Shared package (pipeline package):
  - REG_ZERO=0, REG_RA=31;
  - a 2-bit writeback-source enum WB_ALU/WB_MEM/WB_LINK, used by the control decoder and this block.
- Natural sub-module: regfile_2r1w.
  - Array, synchronous reset clear, one write port, two raw read ports.
  - No bypass, no zero-register rule.
- wb_regfile wraps regfile_2r1w and adds the select mux, register-0 masking, bypass, and trace logic.

Test Plan:
- Reset then read:
  - rst 1 cycle after preloading regs[5]=32'hDEAD -> busA with Ra=5 reads 0; wb_cnt=0; last_wb_valid=0.
- ALU write then read:
  - RegWrite=1, Rw=8, ALUresult=32'h1234, MemtoReg=0, Link=0, WR_pc=32'h40 -> next cycle busA(Ra=8)=32'h1234; wb_cnt=1; last_wb_pc=32'h40; last_wb_valid=1.
- Same-cycle bypass:
  - RegWrite=1, Rw=9, MemtoReg=1, dout=32'hCAFE, Ra=Rb=9 -> busA=busB=32'hCAFE in that same cycle, before the edge.
- Link priority:
  - Link=1, MemtoReg=1, Rw=31, pc_plus4=32'h104 -> regs[31]=32'h104; wb_data=32'h104 in that cycle.
- Zero-register write:
  - RegWrite=1, Rw=0, ALUresult=32'hFFFF -> busA(Ra=0)=0; wb_we=0; wb_cnt unchanged.
  - A bubble (RegWrite=0, Rw=3) leaves regs[3] unchanged.
- Reset vs write, and wrap:
  - rst=1 together with a write to Rw=4 -> regs[4]=0 and wb_cnt=0 after the edge.
  - With CNT_W=4: 16 commits -> wb_cnt wraps to 0 while last_wb_valid stays 1.
